// File: rtl/neureka_tcdm_arbiter.sv
// Shares MP 32-bit TCDM ports between N_REQ wide requesters: round-robin lock, per-port
// grant collection, in-order response reassembly through an {owner, wen} ID FIFO.
module neureka_tcdm_arbiter #(
  parameter int unsigned MP         = 4,
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [N_REQ-1:0]            in_req_i,
  output logic [N_REQ-1:0]            in_gnt_o,
  input  logic [N_REQ-1:0][31:0]      in_add_i,
  input  logic [N_REQ-1:0]            in_wen_i,
  input  logic [N_REQ-1:0][4*MP-1:0]  in_be_i,
  input  logic [N_REQ-1:0][32*MP-1:0] in_data_i,
  output logic [32*MP-1:0]            in_r_data_o,
  output logic [N_REQ-1:0]            in_r_valid_o,
  output logic [MP-1:0]               tcdm_req_o,
  input  logic [MP-1:0]               tcdm_gnt_i,
  output logic [MP-1:0][31:0]         tcdm_add_o,
  output logic [MP-1:0]               tcdm_wen_o,
  output logic [MP-1:0][3:0]          tcdm_be_o,
  output logic [MP-1:0][31:0]         tcdm_data_o,
  input  logic [MP-1:0][31:0]         tcdm_r_data_i,
  input  logic [MP-1:0]               tcdm_r_valid_i
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDW-1:0] owner;
    logic           wen;
  } id_t;

  logic [IDW-1:0]     rr_q, owner_q, win_idx, cur_owner;
  logic               busy_q, win_found, en, active, done;
  logic [MP-1:0]      gmask_q, rmask_q;
  logic [MP-1:0][31:0] rbuf_q;
  logic [PW:0]        wr_q, rd_q;
  logic               full, empty, pop;
  id_t                id_mem [FIFO_DEPTH];
  id_t                head;

  // Reset and clear silence every output combinationally, not just at the next edge.
  assign en    = rst_ni & ~clear_i;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign head  = id_mem[rd_q[PW-1:0]];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && in_req_i[(int'(rr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  // A new access only starts with FIFO room; once locked it runs to completion.
  assign cur_owner = busy_q ? owner_q : win_idx;
  assign active    = en & (busy_q | (win_found & ~full));
  assign done      = active & (&(gmask_q | tcdm_gnt_i));
  assign pop       = en & ~empty & (&(rmask_q | tcdm_r_valid_i));

  always_comb begin
    tcdm_req_o  = '0;
    tcdm_add_o  = '0;
    tcdm_wen_o  = '0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    in_gnt_o    = '0;
    if (active) begin
      for (int p = 0; p < MP; p++) begin
        tcdm_req_o[p]  = ~gmask_q[p];
        tcdm_add_o[p]  = in_add_i[cur_owner] + 32'(4 * p);
        tcdm_wen_o[p]  = in_wen_i[cur_owner];
        tcdm_be_o[p]   = in_be_i[cur_owner][4*p +: 4];
        tcdm_data_o[p] = in_data_i[cur_owner][32*p +: 32];
      end
      in_gnt_o[cur_owner] = done;
    end
  end

  always_comb begin
    in_r_valid_o = '0;
    in_r_data_o  = '0;
    if (pop && head.wen) begin
      in_r_valid_o[head.owner] = 1'b1;
      for (int p = 0; p < MP; p++)
        in_r_data_o[32*p +: 32] = tcdm_r_valid_i[p] ? tcdm_r_data_i[p] : rbuf_q[p];
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      gmask_q <= '0;
      rmask_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else if (clear_i) begin
      rr_q    <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      gmask_q <= '0;
      rmask_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      if (done) begin
        busy_q  <= 1'b0;
        gmask_q <= '0;
        rr_q    <= IDW'((int'(cur_owner) + 1) % N_REQ);
        wr_q    <= wr_q + 1'b1;
      end else if (active) begin
        busy_q  <= 1'b1;
        owner_q <= cur_owner;
        gmask_q <= gmask_q | tcdm_gnt_i;
      end
      if (pop) begin
        rmask_q <= '0;
        rd_q    <= rd_q + 1'b1;
      end else begin
        rmask_q <= rmask_q | tcdm_r_valid_i;
      end
    end
  end

  // NOTE: ID and read-data storage carry no reset; the pointers and masks decide validity.
  always_ff @(posedge clk_i) begin
    if (done) id_mem[wr_q[PW-1:0]] <= '{owner: cur_owner, wen: in_wen_i[cur_owner]};
    for (int p = 0; p < MP; p++)
      if (tcdm_r_valid_i[p]) rbuf_q[p] <= tcdm_r_data_i[p];
  end

endmodule

// File: tb/tb_neureka_tcdm_arbiter.sv
// Directed bench for neureka_tcdm_arbiter: a per-cycle vector table for the main flows,
// plus hand sequences for address wrap, FIFO backpressure, reset and clear.
module tb_neureka_tcdm_arbiter;

  logic               clk_i = 1'b0;
  logic               rst_ni, clear_i;
  logic [1:0]         in_req_i, in_gnt_o, in_wen_i, in_r_valid_o;
  logic [1:0][31:0]   in_add_i;
  logic [1:0][15:0]   in_be_i;
  logic [1:0][127:0]  in_data_i;
  logic [127:0]       in_r_data_o;
  logic [3:0]         tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [3:0][31:0]   tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0][3:0]    tcdm_be_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  neureka_tcdm_arbiter #(.MP(4), .N_REQ(2), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
    .in_be_i(in_be_i), .in_data_i(in_data_i), .in_r_data_o(in_r_data_o),
    .in_r_valid_o(in_r_valid_o), .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i)
  );

  typedef struct packed {
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  exp_treq;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rvalid;
    logic [31:0] exp_add0;
    logic [3:0]  exp_wen;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] req, input logic [3:0] gnt, input logic [3:0] rv);
    in_req_i = req;
    tcdm_gnt_i = gnt;
    tcdm_r_valid_i = rv;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] word(input int i, input int p);
    return 32'hD000_0000 | 32'(i << 8) | 32'(p);
  endfunction

  task automatic set_words(input int i);
    for (int p = 0; p < 4; p++) tcdm_r_data_i[p] = word(i, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last_idx [4];
    logic [3:0][31:0]  exp_add;
    logic [127:0]      exp_data;
    logic [127:0]      wdata0;

    vecs[0]  = '{2'b01, 2'b11, 4'b1111, 4'b0000, 4'b1111, 2'b01, 2'b00, 32'h100, 4'b1111};
    vecs[1]  = '{2'b00, 2'b11, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b01, 32'h0,   4'b0000};
    vecs[2]  = '{2'b01, 2'b11, 4'b0101, 4'b0000, 4'b1111, 2'b00, 2'b00, 32'h100, 4'b1111};
    vecs[3]  = '{2'b01, 2'b11, 4'b0000, 4'b0000, 4'b1010, 2'b00, 2'b00, 32'h100, 4'b1111};
    vecs[4]  = '{2'b01, 2'b11, 4'b1010, 4'b0000, 4'b1010, 2'b01, 2'b00, 32'h100, 4'b1111};
    vecs[5]  = '{2'b00, 2'b11, 4'b0000, 4'b0101, 4'b0000, 2'b00, 2'b00, 32'h0,   4'b0000};
    vecs[6]  = '{2'b00, 2'b11, 4'b0000, 4'b1010, 4'b0000, 2'b00, 2'b01, 32'h0,   4'b0000};
    vecs[7]  = '{2'b11, 2'b11, 4'b1111, 4'b0000, 4'b1111, 2'b10, 2'b00, 32'h200, 4'b1111};
    vecs[8]  = '{2'b11, 2'b11, 4'b1111, 4'b1111, 4'b1111, 2'b01, 2'b10, 32'h100, 4'b1111};
    vecs[9]  = '{2'b11, 2'b11, 4'b1111, 4'b1111, 4'b1111, 2'b10, 2'b01, 32'h200, 4'b1111};
    vecs[10] = '{2'b11, 2'b11, 4'b1111, 4'b1111, 4'b1111, 2'b01, 2'b10, 32'h100, 4'b1111};
    vecs[11] = '{2'b00, 2'b11, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b01, 32'h0,   4'b0000};
    vecs[12] = '{2'b10, 2'b00, 4'b1111, 4'b0000, 4'b1111, 2'b10, 2'b00, 32'h200, 4'b0000};
    vecs[13] = '{2'b10, 2'b10, 4'b1111, 4'b1111, 4'b1111, 2'b10, 2'b00, 32'h200, 4'b1111};
    vecs[14] = '{2'b00, 2'b11, 4'b0000, 4'b1111, 4'b0000, 2'b00, 2'b10, 32'h0,   4'b0000};
    vecs[15] = '{2'b00, 2'b11, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'b00, 32'h0,   4'b0000};

    rst_ni = 1'b0; clear_i = 1'b0;
    in_req_i = '0; in_wen_i = 2'b11; tcdm_gnt_i = '0; tcdm_r_valid_i = '0;
    in_add_i[0] = 32'h100; in_add_i[1] = 32'h200;
    in_be_i = {16'hFFFF, 16'hFFFF};
    in_data_i[0] = {4{32'hAAAA_0000}}; in_data_i[1] = {4{32'hBBBB_1111}};
    set_words(99);
    for (int p = 0; p < 4; p++) last_idx[p] = 0;

    // Reset state, including a request raised while reset is held.
    #2;
    check("reset tcdm_req", 128'(tcdm_req_o), 128'h0);
    check("reset in_gnt", 128'(in_gnt_o), 128'h0);
    check("reset r_valid", 128'(in_r_valid_o), 128'h0);
    drive(2'b01, 4'b1111, 4'b0000);
    check("reset gates req", 128'(tcdm_req_o), 128'h0);
    check("reset tcdm_add", 128'(tcdm_add_o), 128'h0);
    in_req_i = '0; tcdm_gnt_i = '0;
    next_cycle();
    rst_ni = 1'b1;

    // Table: single read, staggered grants, alternation, write-then-read.
    for (int i = 0; i < 16; i++) begin
      in_wen_i = vecs[i].wen;
      set_words(i);
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv);
      for (int p = 0; p < 4; p++) if (vecs[i].rv[p]) last_idx[p] = i;
      for (int p = 0; p < 4; p++)
        exp_add[p] = (vecs[i].exp_add0 == 0) ? 32'h0 : vecs[i].exp_add0 + 32'(4 * p);
      exp_data = '0;
      if (vecs[i].exp_rvalid != 0)
        for (int p = 0; p < 4; p++) exp_data[32*p +: 32] = word(last_idx[p], p);
      check($sformatf("v%0d tcdm_req", i), 128'(tcdm_req_o), 128'(vecs[i].exp_treq));
      check($sformatf("v%0d in_gnt", i), 128'(in_gnt_o), 128'(vecs[i].exp_gnt));
      check($sformatf("v%0d r_valid", i), 128'(in_r_valid_o), 128'(vecs[i].exp_rvalid));
      check($sformatf("v%0d tcdm_add", i), 128'(tcdm_add_o), 128'(exp_add));
      check($sformatf("v%0d tcdm_wen", i), 128'(tcdm_wen_o), 128'(vecs[i].exp_wen));
      check($sformatf("v%0d r_data", i), in_r_data_o, exp_data);
      next_cycle();
    end
    in_wen_i = 2'b11;

    // Address wrap-around plus byte-enable / write-data lane mapping.
    in_add_i[0] = 32'hFFFF_FFF8;
    in_be_i[0] = 16'h5A3C;
    wdata0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    in_data_i[0] = wdata0;
    drive(2'b01, 4'b0000, 4'b0000);
    check("wrap tcdm_add", 128'(tcdm_add_o), {32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8});
    check("lane tcdm_be", 128'(tcdm_be_o), 128'h5A3C);
    check("lane tcdm_data", 128'(tcdm_data_o), wdata0);
    drive(2'b01, 4'b1111, 4'b0000);
    check("wrap in_gnt", 128'(in_gnt_o), 128'h1);
    next_cycle();
    set_words(50);
    drive(2'b00, 4'b0000, 4'b1111);
    check("wrap r_valid", 128'(in_r_valid_o), 128'h1);
    check("wrap r_data", in_r_data_o,
          {32'hD000_3203, 32'hD000_3202, 32'hD000_3201, 32'hD000_3200});
    next_cycle();
    in_add_i[0] = 32'h100;

    // FIFO backpressure: four reads outstanding block the fifth.
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 4'b1111, 4'b0000);
      check($sformatf("fill%0d in_gnt", k), 128'(in_gnt_o), 128'h1);
      next_cycle();
    end
    drive(2'b01, 4'b1111, 4'b0000);
    check("full tcdm_req", 128'(tcdm_req_o), 128'h0);
    check("full in_gnt", 128'(in_gnt_o), 128'h0);
    next_cycle();
    drive(2'b01, 4'b1111, 4'b1111);
    check("full pop tcdm_req", 128'(tcdm_req_o), 128'h0);
    check("full pop r_valid", 128'(in_r_valid_o), 128'h1);
    next_cycle();
    drive(2'b01, 4'b1111, 4'b1111);
    check("push+pop in_gnt", 128'(in_gnt_o), 128'h1);
    check("push+pop r_valid", 128'(in_r_valid_o), 128'h1);
    next_cycle();
    drive(2'b01, 4'b1111, 4'b0000);
    check("refill in_gnt", 128'(in_gnt_o), 128'h1);
    next_cycle();
    drive(2'b01, 4'b1111, 4'b0000);
    check("full again tcdm_req", 128'(tcdm_req_o), 128'h0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 4'b0000, 4'b1111);
      check($sformatf("drain%0d r_valid", k), 128'(in_r_valid_o), 128'h1);
      next_cycle();
    end
    drive(2'b00, 4'b0000, 4'b0000);
    check("drained r_valid", 128'(in_r_valid_o), 128'h0);
    next_cycle();

    // Asynchronous reset, then synchronous clear, each with gmask = 0101.
    for (int mode = 0; mode < 2; mode++) begin
      drive(2'b01, 4'b0101, 4'b0000);
      check($sformatf("abort%0d first req", mode), 128'(tcdm_req_o), 128'hF);
      next_cycle();
      drive(2'b01, 4'b0000, 4'b0000);
      check($sformatf("abort%0d partial req", mode), 128'(tcdm_req_o), 128'hA);
      tcdm_gnt_i = 4'b1010;
      if (mode == 0) rst_ni = 1'b0; else clear_i = 1'b1;
      #1;
      check($sformatf("abort%0d tcdm_req", mode), 128'(tcdm_req_o), 128'h0);
      check($sformatf("abort%0d in_gnt", mode), 128'(in_gnt_o), 128'h0);
      check($sformatf("abort%0d tcdm_add", mode), 128'(tcdm_add_o), 128'h0);
      next_cycle();
      rst_ni = 1'b1; clear_i = 1'b0;
      drive(2'b01, 4'b0000, 4'b0000);
      check($sformatf("abort%0d fresh req", mode), 128'(tcdm_req_o), 128'hF);
      tcdm_gnt_i = 4'b1111;
      #1;
      check($sformatf("abort%0d fresh gnt", mode), 128'(in_gnt_o), 128'h1);
      next_cycle();
      drive(2'b00, 4'b0000, 4'b1111);
      check($sformatf("abort%0d r_valid", mode), 128'(in_r_valid_o), 128'h1);
      next_cycle();
    end

    drive(2'b00, 4'b0000, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
